// File: rtl/mbist_pkg.sv
// March C- BIST shared types: FSM states, element encoding and per-element properties.
// Combinational helpers only; no latency, no flow control.
package mbist_pkg;

    localparam int FAIL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        EL_E0 = 3'd0,
        EL_E1 = 3'd1,
        EL_E2 = 3'd2,
        EL_E3 = 3'd3,
        EL_E4 = 3'd4,
        EL_E5 = 3'd5
    } elem_t;

    // 1 = ascending address order.
    function automatic logic elem_up(elem_t e);
        return !(e == EL_E3 || e == EL_E4);
    endfunction

    function automatic logic elem_two_ops(elem_t e);
        return (e != EL_E0) && (e != EL_E5);
    endfunction

    // Two-op elements are always (read, write).
    function automatic logic op_is_write(elem_t e, logic step);
        case (e)
            EL_E0:   return 1'b1;
            EL_E5:   return 1'b0;
            default: return step;
        endcase
    endfunction

    function automatic logic write_bg(elem_t e);
        return (e == EL_E1) || (e == EL_E3);
    endfunction

    function automatic logic read_bg(elem_t e);
        return (e == EL_E2) || (e == EL_E4);
    endfunction

endpackage

// File: rtl/mbist_rd_compare.sv
// Two-stage expect pipeline aligned to the memory read latency, plus saturating fail counter
// and first-failure capture. Compares two edges after push; no backpressure.
module mbist_rd_compare
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  push_vld_i,
    input  logic [DATA_WIDTH-1:0] push_exp_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  elem_t                 push_elem_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  miss_o,
    output logic [FAIL_CNT_W-1:0] fail_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_element_o,
    output logic [DATA_WIDTH-1:0] fail_expected_o,
    output logic [DATA_WIDTH-1:0] fail_actual_o
);

    logic [1:0]            vld_q;
    logic [DATA_WIDTH-1:0] exp_q  [2];
    logic [ADDR_WIDTH-1:0] addr_q [2];
    logic [2:0]            elem_q [2];
    logic [FAIL_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] faddr_q;
    logic [2:0]            felem_q;
    logic [DATA_WIDTH-1:0] fexp_q, fact_q;

    assign miss_o = vld_q[1] && (mem_rdata_i != exp_q[1]);
    assign cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + FAIL_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            vld_q   <= '0;
            exp_q   <= '{default: '0};
            addr_q  <= '{default: '0};
            elem_q  <= '{default: '0};
            cnt_q   <= '0;
            faddr_q <= '0;
            felem_q <= '0;
            fexp_q  <= '0;
            fact_q  <= '0;
        end else begin
            vld_q     <= {vld_q[0], push_vld_i};
            exp_q[0]  <= push_exp_i;
            exp_q[1]  <= exp_q[0];
            addr_q[0] <= push_addr_i;
            addr_q[1] <= addr_q[0];
            elem_q[0] <= push_elem_i;
            elem_q[1] <= elem_q[0];
            if (miss_o) begin
                cnt_q <= cnt_d;
                if (cnt_q == '0) begin
                    faddr_q <= addr_q[1];
                    felem_q <= elem_q[1];
                    fexp_q  <= exp_q[1];
                    fact_q  <= mem_rdata_i;
                end
            end
        end
    end

    assign fail_count_o    = cnt_q;
    assign fail_addr_o     = faddr_q;
    assign fail_element_o  = felem_q;
    assign fail_expected_o = fexp_q;
    assign fail_actual_o   = fact_q;

endmodule

// File: rtl/mbist_march_engine.sv
// March C- sequencer: one memory op per clock, write data one cycle ahead of its command,
// reads checked two edges after the memory samples them; done 10*CAPACITY+3 cycles after start.
module mbist_march_engine
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                state_q;
    elem_t                 elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  step_q, step_d;
    logic                  last_q, last_op;
    logic                  drain_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    elem_t                 bus_elem_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, done_q, pass_q;
    logic                  is_wr, start_ok, miss;
    logic [ADDR_WIDTH-1:0] end_addr;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign is_wr    = op_is_write(elem_q, step_q);
    assign end_addr = elem_up(elem_q) ? LAST_ADDR : '0;
    assign wdata_d  = {DATA_WIDTH{write_bg(elem_d)}};

    // Successor of the op being issued this edge; its data goes out one cycle early.
    always_comb begin
        elem_d  = elem_q;
        addr_d  = addr_q;
        step_d  = 1'b0;
        last_op = 1'b0;
        if (elem_two_ops(elem_q) && !step_q) begin
            step_d = 1'b1;
        end else if (addr_q != end_addr) begin
            addr_d = elem_up(elem_q) ? addr_q + ADDR_ONE : addr_q - ADDR_ONE;
        end else if (elem_q == EL_E5) begin
            last_op = 1'b1;
        end else begin
            elem_d = elem_t'(elem_q + 3'd1);
            addr_d = elem_up(elem_d) ? '0 : LAST_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            elem_q     <= EL_E0;
            addr_q     <= '0;
            step_q     <= 1'b0;
            last_q     <= 1'b0;
            drain_q    <= 1'b0;
            wr_q       <= 1'b0;
            bus_addr_q <= '0;
            bus_elem_q <= EL_E0;
            exp_q      <= '0;
            rd_vld_q   <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        elem_q  <= EL_E0;
                        addr_q  <= '0;
                        step_q  <= 1'b0;
                        last_q  <= 1'b0;
                        wdata_q <= {DATA_WIDTH{write_bg(EL_E0)}};
                    end
                end
                ST_RUN: begin
                    if (last_q) begin
                        state_q  <= ST_DRAIN;
                        drain_q  <= 1'b0;
                        wr_q     <= 1'b0;
                        rd_vld_q <= 1'b0;
                    end else begin
                        wr_q       <= is_wr;
                        bus_addr_q <= addr_q;
                        bus_elem_q <= elem_q;
                        exp_q      <= {DATA_WIDTH{read_bg(elem_q)}};
                        rd_vld_q   <= !is_wr;
                        elem_q     <= elem_d;
                        addr_q     <= addr_d;
                        step_q     <= step_d;
                        last_q     <= last_op;
                        wdata_q    <= wdata_d;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // The final read is being compared on this same edge.
                        pass_q  <= (fail_count == '0) && !miss;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mbist_rd_compare #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (start_ok),
        .push_vld_i      (rd_vld_q),
        .push_exp_i      (exp_q),
        .push_addr_i     (bus_addr_q),
        .push_elem_i     (bus_elem_q),
        .mem_rdata_i     (mem_rdata),
        .miss_o          (miss),
        .fail_count_o    (fail_count),
        .fail_addr_o     (fail_addr),
        .fail_element_o  (fail_element),
        .fail_expected_o (fail_expected),
        .fail_actual_o   (fail_actual)
    );

    assign mem_write_read = wr_q;
    assign mem_address    = bus_addr_q;
    assign mem_wdata      = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;

endmodule

// File: doc/mbist_march_engine.md
# mbist_march_engine

Built-in self-test sequencer that sits directly upstream of the single-port memory under test (fault-free or fault-injected model). On `start` it runs a March C- algorithm over every address, one memory operation per clock. It drives `write_read`/`address`/`wdata` with the memory's one-cycle write-data skew and compares read data after the memory's two-cycle read latency. It reports pass/fail, a saturating fail count, and first-failure diagnostics.

## Interface
- `DATA_WIDTH`, 8, memory word width
- `ADDR_WIDTH`, 4, memory address width
- `CAPACITY`, 16, number of addresses tested (0 … CAPACITY-1), ≤ 2**ADDR_WIDTH
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin test; sampled only in IDLE or DONE
- `mem_write_read` out 1: 1 = write, 0 = read, to memory `write_read`
- `mem_address` out ADDR_WIDTH: to memory `address`
- `mem_wdata` out DATA_WIDTH: to memory `wdata`; leads its write command by one cycle
- `mem_rdata` in DATA_WIDTH: from memory `rdata`
- `busy` out 1: high in RUN and DRAIN
- `done` out 1: high in DONE until next accepted `start` or `rst`
- `pass` out 1: valid while `done`; 1 = zero miscompares
- `fail_count` out 16: miscompared reads, saturates at 16'hFFFF
- `fail_addr` out ADDR_WIDTH: address of first miscompare
- `fail_element` out 3: March element (0–5) of first miscompare
- `fail_expected`, `fail_actual` out DATA_WIDTH: data of first miscompare

## Operation
- States: IDLE → RUN (on `start`) → DRAIN (after last op issued) → DONE (after 2 drain cycles) → RUN (on `start`).
- Elements, with B0 = all-zeros and B1 = all-ones:
  - E0 ⇑ w0
  - E1 ⇑ (r0, w1)
  - E2 ⇑ (r1, w0)
  - E3 ⇓ (r0, w1)
  - E4 ⇓ (r1, w0)
  - E5 ⇑ r0
- ⇑ runs addresses 0→CAPACITY-1; ⇓ runs CAPACITY-1→0.
- Address counter wraps at the element boundary. The step counter selects the op within an element.
- Both ops of a two-op element go to the same address in consecutive cycles.
- Every read pushes {expected, address, element, valid} into the compare pipeline. Writes push valid=0.
- Miscompare (`mem_rdata` ≠ expected with valid=1):
  - increment `fail_count` (saturating);
  - on the first one only, latch `fail_addr`, `fail_element`, `fail_expected`, `fail_actual`.
- `pass` = (fail_count == 0) when DONE is entered.
- `start` while `busy` is ignored. A `start` accepted in DONE clears `done`, `fail_count` and all diagnostics, then restarts.
- Reset values:
  - all outputs 0;
  - `mem_write_read` 0 (a read, which cannot corrupt memory);
  - state IDLE;
  - pipeline valids cleared.
- `rst` mid-run aborts immediately to these values. No partial result is kept.

## Timing
- `start` sampled at edge S. Op k (k = 0 … 10·CAPACITY-1) appears on `mem_write_read`/`mem_address` during the cycle after edge S+1+k.
- `mem_wdata` carries op k's write value one cycle earlier, because the memory registers wdata before writing.
- The `mem_wdata` switch at each element boundary must obey this lead. At S+1, `mem_wdata` already holds B0.
- A read sampled by the memory at edge E yields `mem_rdata` after edge E+1. The engine compares at edge E+2. The pipeline depth is exactly 2.
- DRAIN lasts 2 cycles so the last E5 read is compared. `mem_write_read` stays 0 in DRAIN, DONE and IDLE.
- `done` rises 10·CAPACITY+3 cycles after S.
- A miscompare on the final read is counted before `done` rises.

## Structure
- Package `mbist_pkg`:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - element encoding E0–E5;
  - per-element constants: direction, op count, op types, data backgrounds;
  - FAIL_CNT_W = 16.
- Sub-module `mbist_rd_compare`:
  - 2-stage expect pipeline, comparator, saturating counter, first-fail capture;
  - inputs: push fields, `mem_rdata`, clear;
  - outputs: `fail_count` and diagnostics.
- Top level holds the FSM, element/address/step counters and the output registers.

## Test plan
- Fault-free memory, defaults, `start` pulse → exactly 160 writes+reads issued; `done`=1 at S+163; `pass`=1; `fail_count`=0.
- Address 5 bit 0 stuck-at-1 → `pass`=0; `fail_count`=3; first fail: addr 5, element 1, expected 8'h00, actual 8'h01.
- Address 0 bit 7 stuck-at-0 → `fail_count`=2 (E2, E4 reads); first fail: addr 0, element 2, expected 8'hFF, actual 8'h7F.
- Fault only on the final E5 read (address 15) → that miscompare is counted before `done`; `fail_addr`=15, element 5.
- `rst` at op 40, then `start` → outputs read as 0 during reset; the rerun is a full 160-op test with correct result.
- `start` pulsed during RUN → ignored, op count unchanged. `start` in DONE → results cleared, a second full run completes.
